// File: rtl/phase_diff.sv
// phase_diff: wrapped phase difference of two hydrophone channels.
//   out = in_phase1 - in_phase2, wrapped into (-180, +180] deg, loaded on data_rdy.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset, clears out (priority over data_rdy)
//   data_rdy   - one-cycle strobe: inputs valid, compute and load out
//   in_phase1  - channel 1 phase, signed, deg * 2^FRAC
//   in_phase2  - channel 2 phase, signed, deg * 2^FRAC
//   out        - registered wrapped difference, signed, deg * 2^FRAC
module phase_diff #(
  parameter int W    = 19,
  parameter int FRAC = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_rdy,
  input  logic [W-1:0] in_phase1,
  input  logic [W-1:0] in_phase2,
  output logic [W-1:0] out
);

  localparam int P180_I = 180 * (2 ** FRAC);
  localparam int P360_I = 360 * (2 ** FRAC);

  localparam logic signed [W:0] P180 = (W+1)'(P180_I);
  localparam logic signed [W:0] N180 = (W+1)'(-P180_I);
  localparam logic signed [W:0] P360 = (W+1)'(P360_I);

  logic signed [W:0]   d;
  logic signed [W:0]   w;
  logic        [W-1:0] out_d;
  logic        [W-1:0] out_q;

  always_comb begin
    // One extra bit so the raw difference can never overflow.
    d = {in_phase1[W-1], in_phase1} - {in_phase2[W-1], in_phase2};

    // Half-open interval: +180 is kept, -180 maps to +180.
    if (d > P180) begin
      w = d - P360;
    end else if (d <= N180) begin
      w = d + P360;
    end else begin
      w = d;
    end

    out_d = out_q;
    if (data_rdy) begin
      out_d = w[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_phase_diff.sv
module tb_phase_diff;

  localparam int W    = 19;
  localparam int FRAC = 10;

  typedef struct {
    string        name;
    logic [W-1:0] exp;
  } item_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         data_rdy = 1'b0;
  logic [W-1:0] p1 = '0;
  logic [W-1:0] p2 = '0;
  logic [W-1:0] out;

  item_t        q[$];
  logic         chk = 1'b0;
  int           tests = 0;
  int           fails = 0;

  phase_diff #(.W(W), .FRAC(FRAC)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_rdy  (data_rdy),
    .in_phase1 (p1),
    .in_phase2 (p2),
    .out       (out)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the output expected after the next edge.
  task automatic step(input logic r, input logic rdy,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] e, input string nm);
    item_t it;
    @(posedge clk);
    #2;
    reset    = r;
    data_rdy = rdy;
    p1       = a;
    p2       = b;
    it.name  = nm;
    it.exp   = e;
    q.push_back(it);
    chk      = 1'b1;
  endtask

  // Monitor: every edge whose inputs were tagged for checking yields one result.
  initial begin
    logic  chk_s;
    item_t it;
    forever begin
      @(posedge clk);
      chk_s = chk;
      @(negedge clk);
      if (chk_s) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: out=%05h, no expected value queued", out);
        end else begin
          it = q.pop_front();
          if (out !== it.exp) begin
            fails++;
            $display("FAIL %s: out=%05h expected=%05h", it.name, out, it.exp);
          end
        end
      end
    end
  end

  initial begin
    int budget;
    // reset, then hold with data_rdy low
    step(1'b1, 1'b0, 19'h00000, 19'h00000, 19'h00000, "reset_1");
    step(1'b1, 1'b0, 19'h00000, 19'h00000, 19'h00000, "reset_2");
    step(1'b0, 1'b0, 19'h12345, 19'h01000, 19'h00000, "idle_hold_1");
    step(1'b0, 1'b0, 19'h12345, 19'h01000, 19'h00000, "idle_hold_2");
    // main function and boundaries
    step(1'b0, 1'b1, 19'h00000, 19'h00000, 19'h00000, "zero_zero");
    step(1'b0, 1'b1, 19'h2D000, 19'h00000, 19'h2D000, "d_plus180");
    step(1'b0, 1'b1, 19'h00000, 19'h2D000, 19'h2D000, "d_minus180");
    step(1'b0, 1'b1, 19'h2D000, 19'h53000, 19'h00000, "d_plus360");
    step(1'b0, 1'b1, 19'h53000, 19'h2D000, 19'h00000, "d_minus360");
    step(1'b0, 1'b1, 19'h08000, 19'h04000, 19'h04000, "p32_m_p16");
    step(1'b0, 0, 19'h11111, 19'h22222, 19'h04000, "hold_after_p16");
    step(1'b0, 1'b1, 19'h78000, 19'h04000, 19'h74000, "m32_m_p16");
    step(1'b0, 1'b1, 19'h2D001, 19'h00000, 19'h53001, "just_above_p180");
    step(1'b0, 1'b1, 19'h53001, 19'h00000, 19'h53001, "just_above_m180");
    step(1'b0, 1'b1, 19'h2A800, 19'h55800, 19'h7B000, "p170_m_m170");
    // reset wins over a strobe, then hold with new inputs
    step(1'b1, 1'b1, 19'h2A800, 19'h55800, 19'h00000, "reset_over_rdy");
    step(1'b0, 1'b0, 19'h08000, 19'h04000, 19'h00000, "hold_after_reset");
    @(posedge clk);
    #2;
    chk      = 1'b0;
    data_rdy = 1'b0;
    budget = 0;
    while (q.size() != 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
